// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet parser.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      LEN     = 3'd2,
      PAYLOAD = 3'd3,
      CHK     = 3'd4,
      HOLD    = 3'd5
   } parser_state_t;

   localparam logic [7:0] ACK_BYTE     = 8'h06;
   localparam logic [7:0] NAK_BYTE     = 8'h15;
   localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: counts enabled cycles while running and fires a
// one-cycle expire when the count reaches TIMEOUT_CYCLES; clear always wins.
module uart_byte_timeout #(
   parameter int  TIMEOUT_CYCLES = 500_000,
   localparam int CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_ena,
   input  logic i_run,
   input  logic i_clear,
   output logic o_expire
);

   logic [CW-1:0] r_count;
   logic          w_at_limit;

   assign w_at_limit = (r_count == CW'(TIMEOUT_CYCLES - 1));
   assign o_expire   = i_ena && i_run && !i_clear && w_at_limit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_ena) begin
         if (i_clear || !i_run || o_expire) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_packet_parser.sv
// Framed command parser: SYNC, CMD, LEN, PAYLOAD[LEN], CHK -> held packet.
// Optional ACK/NAK byte generation is enabled with `define UART_PKT_ACK_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | hunting for SYNC_BYTE, other bytes dropped
//   CMD     | expecting command byte
//   LEN     | expecting payload length
//   PAYLOAD | collecting payload bytes
//   CHK     | expecting checksum byte
//   HOLD    | packet presented, waiting for consumer
module uart_packet_parser
   import uart_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    MAX_PAYLOAD    = 8,
   parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = DEFAULT_SYNC,
   parameter int                    TIMEOUT_CYCLES = 500_000,
   localparam int                   LW             = $clog2(MAX_PAYLOAD + 1)
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              ena,
   input  logic [DATA_WIDTH-1:0]             rx_data,
   input  logic                              rx_valid,
   output logic                              rx_ready,
   output logic [DATA_WIDTH-1:0]             pkt_cmd,
   output logic [LW-1:0]                     pkt_len,
   output logic [DATA_WIDTH*MAX_PAYLOAD-1:0] pkt_payload,
   output logic                              pkt_valid,
   input  logic                              pkt_ready,
   output logic                              err_chk,
   output logic                              err_len,
   output logic                              err_timeout,
   output logic [7:0]                        ack_data,
   output logic                              ack_valid
);

   parser_state_t                     r_state;
   parser_state_t                     w_next;
   logic [DATA_WIDTH-1:0]             r_cmd;
   logic [DATA_WIDTH-1:0]             r_sum;
   logic [LW-1:0]                     r_len;
   logic [LW-1:0]                     r_idx;
   logic [DATA_WIDTH*MAX_PAYLOAD-1:0] r_payload;
   logic                              r_err_chk;
   logic                              r_err_len;
   logic                              r_err_timeout;

   logic w_accept;
   logic w_expire;
   logic w_run;
   logic w_len_over;
   logic w_len_zero;
   logic w_last_pl;
   logic w_chk_ok;

   assign w_accept   = rx_valid && rx_ready && ena;
   assign w_run      = (r_state == CMD) || (r_state == LEN) ||
                       (r_state == PAYLOAD) || (r_state == CHK);
   assign w_len_over = (rx_data > DATA_WIDTH'(MAX_PAYLOAD));
   assign w_len_zero = (rx_data == '0);
   assign w_last_pl  = (r_idx == (r_len - LW'(1)));
   assign w_chk_ok   = (rx_data == r_sum);

   uart_byte_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_ena    (ena),
      .i_run    (w_run),
      .i_clear  (w_accept),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // expire is already suppressed by the timeout block when a byte lands
   always_comb begin
      w_next = r_state;
      if (w_expire) begin
         w_next = IDLE;
      end else if (w_accept) begin
         case (r_state)
            IDLE:    if (rx_data == SYNC_BYTE) w_next = CMD;
            CMD:     w_next = LEN;
            LEN: begin
               if (w_len_over)      w_next = IDLE;
               else if (w_len_zero) w_next = CHK;
               else                 w_next = PAYLOAD;
            end
            PAYLOAD: if (w_last_pl) w_next = CHK;
            CHK:     w_next = w_chk_ok ? HOLD : IDLE;
            default: w_next = r_state;
         endcase
      end else if ((r_state == HOLD) && ena && pkt_ready) begin
         w_next = IDLE;
      end
   end

   always_comb begin
      rx_ready  = (r_state != HOLD);
      pkt_valid = (r_state == HOLD);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cmd         <= '0;
         r_sum         <= '0;
         r_len         <= '0;
         r_idx         <= '0;
         r_payload     <= '0;
         r_err_chk     <= 1'b0;
         r_err_len     <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_err_chk     <= 1'b0;
         r_err_len     <= 1'b0;
         r_err_timeout <= 1'b0;
         if (ena) begin
            if (w_expire) begin
               r_err_timeout <= 1'b1;
            end
            if (w_accept) begin
               case (r_state)
                  IDLE: begin
                     if (rx_data == SYNC_BYTE) begin
                        r_payload <= '0;
                        r_sum     <= '0;
                        r_idx     <= '0;
                     end
                  end
                  CMD: begin
                     r_cmd <= rx_data;
                     r_sum <= rx_data;
                  end
                  LEN: begin
                     if (w_len_over) begin
                        r_err_len <= 1'b1;
                     end else begin
                        r_len <= rx_data[LW-1:0];
                        r_sum <= r_sum + rx_data;
                        r_idx <= '0;
                     end
                  end
                  PAYLOAD: begin
                     for (int i = 0; i < MAX_PAYLOAD; i++) begin
                        if (r_idx == LW'(i)) begin
                           r_payload[DATA_WIDTH*i +: DATA_WIDTH] <= rx_data;
                        end
                     end
                     r_sum <= r_sum + rx_data;
                     r_idx <= r_idx + LW'(1);
                  end
                  CHK: begin
                     if (!w_chk_ok) begin
                        r_err_chk <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign pkt_cmd     = r_cmd;
   assign pkt_len     = r_len;
   assign pkt_payload = r_payload;
   assign err_chk     = r_err_chk;
   assign err_len     = r_err_len;
   assign err_timeout = r_err_timeout;

`ifdef UART_PKT_ACK_EN
   logic [7:0] r_ack_data;
   logic       r_ack_valid;

   // strobe lands on the same edge that moves CHK -> HOLD or raises err_chk
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ack_data  <= '0;
         r_ack_valid <= 1'b0;
      end else begin
         r_ack_valid <= 1'b0;
         if (w_accept && (r_state == CHK)) begin
            r_ack_valid <= 1'b1;
            r_ack_data  <= w_chk_ok ? ACK_BYTE : NAK_BYTE;
         end
      end
   end

   assign ack_data  = r_ack_data;
   assign ack_valid = r_ack_valid;
`else
   assign ack_data  = '0;
   assign ack_valid = 1'b0;
`endif

endmodule

// File: tb/tb_uart_packet_parser.sv
// Scoreboard bench for uart_packet_parser: directed frames then random frames,
// expected outcomes computed from the framing rules and checked by a monitor.
module tb_uart_packet_parser;

   localparam int MAXP = 8;
   localparam int LW   = $clog2(MAXP + 1);
   localparam int TO   = 20;

   localparam int EV_PKT = 0;
   localparam int EV_CHK = 1;
   localparam int EV_LEN = 2;
   localparam int EV_TO  = 3;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            ena = 1'b1;
   logic [7:0]      rx_data = 8'h00;
   logic            rx_valid = 1'b0;
   logic            rx_ready;
   logic [7:0]      pkt_cmd;
   logic [LW-1:0]   pkt_len;
   logic [8*MAXP-1:0] pkt_payload;
   logic            pkt_valid;
   logic            pkt_ready = 1'b0;
   logic            err_chk;
   logic            err_len;
   logic            err_timeout;
   logic [7:0]      ack_data;
   logic            ack_valid;

   uart_packet_parser #(
      .DATA_WIDTH     (8),
      .MAX_PAYLOAD    (MAXP),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ena         (ena),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .pkt_cmd     (pkt_cmd),
      .pkt_len     (pkt_len),
      .pkt_payload (pkt_payload),
      .pkt_valid   (pkt_valid),
      .pkt_ready   (pkt_ready),
      .err_chk     (err_chk),
      .err_len     (err_len),
      .err_timeout (err_timeout),
      .ack_data    (ack_data),
      .ack_valid   (ack_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [7:0]  cmd;
      int          len;
      logic [63:0] payload;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic prev_pv = 1'b0;
   logic hs_q = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // consumer takes held packets after a random delay
   always @(negedge clk) pkt_ready <= pkt_valid && ($urandom_range(0, 2) == 0);

   always @(posedge clk) hs_q <= reset_n && ena && pkt_valid && pkt_ready;

   always @(negedge clk) begin : mon
      int   ev;
      int   nev;
      exp_t e;
      logic exp_av;
      logic [7:0] exp_ad;
      if (reset_n) begin
         ev  = -1;
         nev = 0;
         if (pkt_valid && !prev_pv) begin ev = EV_PKT; nev++; end
         if (err_chk)     begin ev = EV_CHK; nev++; end
         if (err_len)     begin ev = EV_LEN; nev++; end
         if (err_timeout) begin ev = EV_TO;  nev++; end
         if (nev > 1) begin
            n_cmp++; n_bad++;
            $display("FAIL multi_event: got %0d events in one cycle required 1", nev);
         end
         if (hs_q) begin
            check("release_pkt_valid", 64'(pkt_valid), 64'(0));
            check("release_rx_ready", 64'(rx_ready), 64'(1));
         end else if (pkt_valid && prev_pv) begin
            check("hold_cmd", 64'(pkt_cmd), 64'(cur.cmd));
            check("hold_payload", pkt_payload, cur.payload);
         end
         if (ev >= 0) begin
            if (q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_event: got kind %0d required none", ev);
            end else begin
               e = q.pop_front();
               check("event_kind", 64'(ev), 64'(e.kind));
               if (ev == EV_PKT) begin
                  check("pkt_cmd", 64'(pkt_cmd), 64'(e.cmd));
                  check("pkt_len", 64'(pkt_len), 64'(e.len));
                  check("pkt_payload", pkt_payload, e.payload);
                  check("hold_rx_ready", 64'(rx_ready), 64'(0));
                  cur = e;
               end
               if (ev == EV_CHK) check("chk_no_valid", 64'(pkt_valid), 64'(0));
            end
         end
`ifdef UART_PKT_ACK_EN
         exp_av = (ev == EV_PKT) || (ev == EV_CHK);
         exp_ad = (ev == EV_PKT) ? 8'h06 : 8'h15;
         if (exp_av || ack_valid) begin
            check("ack_valid", 64'(ack_valid), 64'(exp_av));
            if (exp_av) check("ack_data", 64'(ack_data), 64'(exp_ad));
         end
`else
         exp_av = 1'b0;
         exp_ad = 8'h00;
         if ((ev >= 0) || ack_valid) begin
            check("ack_valid_off", 64'(ack_valid), 64'(exp_av));
            check("ack_data_off", 64'(ack_data), 64'(exp_ad));
         end
`endif
      end
      prev_pv <= reset_n && pkt_valid;
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         n_cmp++; n_bad++;
         $display("FAIL send_wait: rx_ready stuck at 0 required 1");
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic push_err(input int kind);
      exp_t e;
      e.kind = kind; e.cmd = 8'h00; e.len = 0; e.payload = '0;
      q.push_back(e);
   endtask

   // checksum = modulo-256 sum of CMD, LEN and payload; delta != 0 corrupts it
   task automatic do_frame(input logic [7:0] cmd, input int len, input logic [63:0] pl,
                           input logic [7:0] delta);
      exp_t       e;
      logic [7:0] sum;
      logic [63:0] mp;
      sum = cmd + 8'(len);
      mp  = '0;
      for (int i = 0; i < len; i++) begin
         sum = sum + pl[8*i +: 8];
         mp[8*i +: 8] = pl[8*i +: 8];
      end
      e.kind = (delta == 8'h00) ? EV_PKT : EV_CHK;
      e.cmd = cmd; e.len = len; e.payload = mp;
      q.push_back(e);
      send_byte(8'hA5); gap();
      send_byte(cmd); gap();
      send_byte(8'(len));
      for (int i = 0; i < len; i++) begin
         gap();
         send_byte(pl[8*i +: 8]);
      end
      gap();
      send_byte(sum + delta);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, 64'(rx_ready), 64'(1));
      check({tag, "_pkt_valid"}, 64'(pkt_valid), 64'(0));
      check({tag, "_pkt_cmd"}, 64'(pkt_cmd), 64'(0));
      check({tag, "_pkt_len"}, 64'(pkt_len), 64'(0));
      check({tag, "_pkt_payload"}, pkt_payload, 64'(0));
      check({tag, "_errs"}, 64'({err_chk, err_len, err_timeout}), 64'(0));
      check({tag, "_ack"}, 64'({ack_valid, ack_data}), 64'(0));
   endtask

   initial begin
      int w;
      exp_t e;
      logic [7:0] b;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      @(negedge clk);

      do_frame(8'h10, 2, 64'h4433, 8'h00);
      do_frame(8'h10, 2, 64'h4433, 8'hFF);
      do_frame(8'h10, 2, 64'h4433, 8'h00);

      push_err(EV_LEN);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h09);
      do_frame(8'h22, 0, 64'h0, 8'h00);

      send_byte(8'hA5); send_byte(8'h10);
      repeat (TO - 1) @(negedge clk);
      #2;
      push_err(EV_TO);
      @(negedge clk);
      #2;
      check("timeout_at_limit", 64'(q.size()), 64'(0));
      repeat (10) @(negedge clk);
      do_frame(8'h31, 1, 64'h5A, 8'h00);

      send_byte(8'h00); send_byte(8'hFF);
      do_frame(8'h05, 1, 64'hA5, 8'h00);

      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      do_frame(8'h44, 3, 64'h030201, 8'h00);

      e.kind = EV_PKT; e.cmd = 8'h10; e.len = 1; e.payload = 64'h33;
      q.push_back(e);
      send_byte(8'hA5); send_byte(8'h10);
      ena = 1'b0;
      repeat (50) @(negedge clk);
      ena = 1'b1;
      send_byte(8'h01); send_byte(8'h33); send_byte(8'h44);

      for (int f = 0; f < 60; f++) begin
         int t;
         t = $urandom_range(0, 9);
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            send_byte(b);
         end
         if (t <= 5) begin
            do_frame(8'($urandom), $urandom_range(0, MAXP), {$urandom, $urandom}, 8'h00);
         end else if (t <= 7) begin
            do_frame(8'($urandom), $urandom_range(0, MAXP), {$urandom, $urandom},
                     8'($urandom_range(1, 255)));
         end else if (t == 8) begin
            push_err(EV_LEN);
            send_byte(8'hA5); send_byte(8'($urandom));
            send_byte(8'($urandom_range(MAXP + 1, 255)));
         end else begin
            push_err(EV_TO);
            send_byte(8'hA5); send_byte(8'($urandom));
            repeat (TO + 4) @(negedge clk);
         end
      end

      w = 0;
      while (q.size() != 0 && w < 500) begin
         @(negedge clk);
         w++;
      end
      check("queue_drained", 64'(q.size()), 64'(0));
      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
